// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the shared-RAM arbiter.
// Holds the arbiter FSM state encoding, the grant encoding and the default
// shared-RAM address width.
package jtkiwi_pkg;

  localparam int unsigned SHRAM_AW = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2
  } shram_st_e;

  typedef enum logic {
    GR_MAIN = 1'b0,
    GR_SUB  = 1'b1
  } shram_gr_e;

endpackage

// File: rtl/jtkiwi_shram_port.sv
// Per-requester front end of the shared-RAM arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cs         : requester chip select, held for the whole bus cycle
//   set_done   : arbiter strobe, the access for this requester completes now
//   capture    : arbiter strobe, load ram_dout into the read-data register
//   ram_dout   : RAM read data
//   pending    : cs asserted and the access not yet completed
//   busy       : wait request back to the CPU (same as pending)
//   dout       : read data held until this requester's next read
module jtkiwi_shram_port (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       set_done,
  input  logic       capture,
  input  logic [7:0] ram_dout,
  output logic       pending,
  output logic       busy,
  output logic [7:0] dout
);

  logic done_q;

  // done only survives while cs stays high, so a held cs cannot retrigger
  // and an aborted access (cs already low) never marks itself done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      dout   <= 8'h00;
    end else begin
      if (!cs) begin
        done_q <= 1'b0;
      end else if (set_done) begin
        done_q <= 1'b1;
      end
      if (capture) begin
        dout <= ram_dout;
      end
    end
  end

  assign busy    = cs & ~done_q;
  assign pending = busy;

endmodule

// File: rtl/jtkiwi_shram_arb.sv
// Arbiter for the 8kB RAM shared by the main CPU and the sound CPU.
// Sequences the two chip-select requesters onto one single-port RAM with a
// fixed read latency of RD_LAT cycles, round-robin on ties.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   main_cs/we/addr/din        : main CPU request
//   main_dout, main_busy       : main CPU read data and wait request
//   sub_cs/we/addr/din         : sound CPU request
//   sub_dout, sub_busy         : sound CPU read data and wait request
//   ram_addr, ram_din, ram_we  : RAM side, ram_we is a one-cycle pulse
//   ram_dout                   : RAM read data, valid RD_LAT cycles after addr
module jtkiwi_shram_arb
  import jtkiwi_pkg::*;
#(
  parameter int unsigned AW     = SHRAM_AW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          main_cs,
  input  logic          main_we,
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_din,
  output logic [7:0]    main_dout,
  output logic          main_busy,
  input  logic          sub_cs,
  input  logic          sub_we,
  input  logic [AW-1:0] sub_addr,
  input  logic [7:0]    sub_din,
  output logic [7:0]    sub_dout,
  output logic          sub_busy,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout
);

  localparam int unsigned CW = 2;
  localparam logic [CW-1:0] CntLoad = CW'(RD_LAT - 1);

  shram_st_e     state_q;
  shram_gr_e     grant_q, last_grant_q;
  logic          gnt_we_q;
  logic [CW-1:0] cnt_q;

  logic          main_pend, sub_pend;
  logic          main_set, sub_set, main_cap, sub_cap;
  logic          rd_complete, wr_complete;
  shram_gr_e     win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [7:0]    win_din;

  // Winner selection, only consumed in IDLE.
  always_comb begin
    win = GR_SUB;
    if (main_pend && sub_pend) begin
      win = (last_grant_q == GR_SUB) ? GR_MAIN : GR_SUB;
    end else if (main_pend) begin
      win = GR_MAIN;
    end
    win_we   = (win == GR_MAIN) ? main_we   : sub_we;
    win_addr = (win == GR_MAIN) ? main_addr : sub_addr;
    win_din  = (win == GR_MAIN) ? main_din  : sub_din;
  end

  // Completion strobes towards the port front ends.
  always_comb begin
    rd_complete = (state_q == WAIT) && (cnt_q == '0);
    wr_complete = (state_q == ACC) && gnt_we_q;
    main_set    = (rd_complete || wr_complete) && (grant_q == GR_MAIN);
    sub_set     = (rd_complete || wr_complete) && (grant_q == GR_SUB);
    main_cap    = rd_complete && (grant_q == GR_MAIN);
    sub_cap     = rd_complete && (grant_q == GR_SUB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= GR_MAIN;
      last_grant_q <= GR_SUB;
      gnt_we_q     <= 1'b0;
      cnt_q        <= '0;
      ram_addr     <= '0;
      ram_din      <= 8'h00;
      ram_we       <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (main_pend || sub_pend) begin
            grant_q      <= win;
            last_grant_q <= win;
            gnt_we_q     <= win_we;
            ram_addr     <= win_addr;
            ram_din      <= win_din;
            // Raised here so the pulse lines up with the ACC cycle.
            ram_we       <= win_we;
            state_q      <= ACC;
          end
        end
        ACC: begin
          if (gnt_we_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= CntLoad;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  jtkiwi_shram_port u_main (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (main_cs),
    .set_done (main_set),
    .capture  (main_cap),
    .ram_dout (ram_dout),
    .pending  (main_pend),
    .busy     (main_busy),
    .dout     (main_dout)
  );

  jtkiwi_shram_port u_sub (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (sub_cs),
    .set_done (sub_set),
    .capture  (sub_cap),
    .ram_dout (ram_dout),
    .pending  (sub_pend),
    .busy     (sub_busy),
    .dout     (sub_dout)
  );

endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Bench for jtkiwi_shram_arb: one instance with RD_LAT=1 and one with RD_LAT=3,
// each attached to a behavioural RAM. RAM writes are checked against a queue
// of expected {addr,data} pushed when a write request is driven.
module tb_jtkiwi_shram_arb;
  import jtkiwi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // RD_LAT=1 instance signals
  logic        rst1_n;
  logic        m1_cs, m1_we, s1_cs, s1_we;
  logic [12:0] m1_addr, s1_addr, ram_addr1;
  logic [7:0]  m1_din, s1_din, m1_dout, s1_dout, ram_din1, ram_dout1;
  logic        m1_busy, s1_busy, ram_we1;
  // RD_LAT=3 instance signals
  logic        rst3_n;
  logic        m3_cs, m3_we, s3_cs, s3_we;
  logic [12:0] m3_addr, s3_addr, ram_addr3;
  logic [7:0]  m3_din, s3_din, m3_dout, s3_dout, ram_din3, ram_dout3;
  logic        m3_busy, s3_busy, ram_we3;

  logic [7:0]  mem1 [8192];
  logic [7:0]  mem3 [8192];
  logic [7:0]  p3a, p3b;
  logic [20:0] wq1 [$];
  logic [20:0] wq3 [$];
  logic [20:0] w1_exp, w3_exp;
  bit          order_q [$];

  jtkiwi_shram_arb #(.AW(13), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst1_n),
    .main_cs(m1_cs), .main_we(m1_we), .main_addr(m1_addr), .main_din(m1_din),
    .main_dout(m1_dout), .main_busy(m1_busy),
    .sub_cs(s1_cs), .sub_we(s1_we), .sub_addr(s1_addr), .sub_din(s1_din),
    .sub_dout(s1_dout), .sub_busy(s1_busy),
    .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_we(ram_we1), .ram_dout(ram_dout1)
  );

  jtkiwi_shram_arb #(.AW(13), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n),
    .main_cs(m3_cs), .main_we(m3_we), .main_addr(m3_addr), .main_din(m3_din),
    .main_dout(m3_dout), .main_busy(m3_busy),
    .sub_cs(s3_cs), .sub_we(s3_we), .sub_addr(s3_addr), .sub_din(s3_din),
    .sub_dout(s3_dout), .sub_busy(s3_busy),
    .ram_addr(ram_addr3), .ram_din(ram_din3), .ram_we(ram_we3), .ram_dout(ram_dout3)
  );

  // Behavioural RAMs: 1-cycle and 3-cycle read latency.
  always @(posedge clk) begin
    if (ram_we1) mem1[ram_addr1] <= ram_din1;
    ram_dout1 <= mem1[ram_addr1];
  end

  always @(posedge clk) begin
    if (ram_we3) mem3[ram_addr3] <= ram_din3;
    p3a       <= mem3[ram_addr3];
    p3b       <= p3a;
    ram_dout3 <= p3b;
  end

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every write pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (rst1_n && ram_we1) begin
      if (wq1.size() == 0) check("ram1 unexpected write pulse", 1, 0);
      else begin
        w1_exp = wq1.pop_front();
        check("ram1 write addr/data", int'({ram_addr1, ram_din1}), int'(w1_exp));
      end
    end
  end

  always @(negedge clk) begin
    if (rst3_n && ram_we3) begin
      if (wq3.size() == 0) check("ram3 unexpected write pulse", 1, 0);
      else begin
        w3_exp = wq3.pop_front();
        check("ram3 write addr/data", int'({ram_addr3, ram_din3}), int'(w3_exp));
      end
    end
  end

  task automatic set_req(input int d, input bit side, input logic cs, input logic we,
                         input logic [12:0] addr, input logic [7:0] din);
    if (d == 1) begin
      if (!side) begin m1_cs = cs; m1_we = we; m1_addr = addr; m1_din = din; end
      else       begin s1_cs = cs; s1_we = we; s1_addr = addr; s1_din = din; end
    end else begin
      if (!side) begin m3_cs = cs; m3_we = we; m3_addr = addr; m3_din = din; end
      else       begin s3_cs = cs; s3_we = we; s3_addr = addr; s3_din = din; end
    end
  endtask

  function automatic logic get_busy(input int d, input bit side);
    if (d == 1) return side ? s1_busy : m1_busy;
    return side ? s3_busy : m3_busy;
  endfunction

  function automatic logic [7:0] get_dout(input int d, input bit side);
    if (d == 1) return side ? s1_dout : m1_dout;
    return side ? s3_dout : m3_dout;
  endfunction

  // Called just after a rising edge; returns just after a rising edge with
  // cs low long enough for done to have cleared.
  task automatic run_access(input int d, input bit side, input logic we,
                            input logic [12:0] addr, input logic [7:0] din,
                            input int exp_cyc, input logic [7:0] exp_dout,
                            input int hold, input string nm);
    int n;
    n = 0;
    if (we) begin
      if (d == 1) wq1.push_back({addr, din});
      else        wq3.push_back({addr, din});
    end
    set_req(d, side, 1'b1, we, addr, din);
    @(negedge clk);
    while (get_busy(d, side) && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({nm, " busy cycles"}, n, exp_cyc);
    check({nm, " dout"}, int'(get_dout(d, side)), int'(exp_dout));
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1 set_req(d, side, 1'b0, 1'b0, addr, din);
    @(posedge clk);
    #1;
  endtask

  task automatic alt_side(input bit side, input logic [12:0] addr);
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      set_req(1, side, 1'b1, 1'b0, addr, 8'h00);
      @(negedge clk);
      while (get_busy(1, side) && n < 40) begin
        n++;
        @(negedge clk);
      end
      if (n >= 40) check("alternation busy timeout", n, 0);
      order_q.push_back(side);
      @(posedge clk);
      #1 set_req(1, side, 1'b0, 1'b0, addr, 8'h00);
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    bit          side;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  din;
    int          hold;
    int          exp_cyc;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int nm, ns, n;

    // side, we, addr, din, hold, busy cycles, dout afterwards
    vecs[0] = '{1'b0, 1'b0, 13'h0123, 8'h00, 0,  3, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 13'h1FFF, 8'hC3, 10, 2, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 13'h0000, 8'h11, 0,  2, 8'h5A};
    vecs[3] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 0,  3, 8'hC3};
    vecs[4] = '{1'b0, 1'b0, 13'h0000, 8'h00, 0,  3, 8'h11};
    vecs[5] = '{1'b0, 1'b0, 13'h1FFF, 8'h00, 0,  3, 8'hC3};
    vecs[6] = '{1'b1, 1'b0, 13'h0123, 8'h00, 0,  3, 8'h5A};

    for (int i = 0; i < 8192; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
    mem1[13'h0123] = 8'h5A;
    mem1[13'h0010] = 8'hA1;
    mem1[13'h0020] = 8'hB2;
    mem3[13'h0456] = 8'h99;

    rst1_n = 1'b0;
    rst3_n = 1'b0;
    set_req(1, 1'b0, 1'b0, 1'b0, 13'h0, 8'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 13'h0, 8'h0);
    set_req(3, 1'b0, 1'b0, 1'b0, 13'h0, 8'h0);
    set_req(3, 1'b1, 1'b0, 1'b0, 13'h0, 8'h0);
    repeat (2) @(posedge clk);
    #1;
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    @(posedge clk);
    #1;

    check("reset ram_we", int'(ram_we1), 0);
    check("reset ram_addr", int'(ram_addr1), 0);
    check("reset ram_din", int'(ram_din1), 0);
    check("reset main_dout", int'(m1_dout), 0);
    check("reset sub_dout", int'(s1_dout), 0);
    check("reset main_busy", int'(m1_busy), 0);

    // Sequential accesses, RD_LAT=1.
    for (int i = 0; i < 7; i++) begin
      run_access(1, vecs[i].side, vecs[i].we, vecs[i].addr, vecs[i].din,
                 vecs[i].exp_cyc, vecs[i].exp_dout, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Simultaneous first requests: main first, sub right after.
    nm = 0;
    ns = 0;
    set_req(1, 1'b0, 1'b1, 1'b0, 13'h0010, 8'h00);
    set_req(1, 1'b1, 1'b1, 1'b0, 13'h0020, 8'h00);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m1_busy) nm++;
      if (s1_busy) ns++;
    end
    check("tie main busy cycles", nm, 3);
    check("tie sub busy cycles", ns, 6);
    check("tie main dout", int'(m1_dout), 8'hA1);
    check("tie sub dout", int'(s1_dout), 8'hB2);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 1'b0, 1'b0, 13'h0010, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 13'h0020, 8'h00);
    @(posedge clk);
    #1;

    // Continuous re-requesting from both sides alternates M,S,M,S,...
    fork
      alt_side(1'b0, 13'h0010);
      alt_side(1'b1, 13'h0020);
    join
    check("alternation count", order_q.size(), 6);
    if (order_q.size() == 6) begin
      for (int k = 0; k < 6; k++) check($sformatf("alternation slot %0d", k),
                                        int'(order_q[k]), k % 2);
    end

    // Abort: sub write granted, cs dropped during ACC.
    wq1.push_back({13'h0777, 8'h3C});
    set_req(1, 1'b1, 1'b1, 1'b1, 13'h0777, 8'h3C);
    @(posedge clk);
    #1 set_req(1, 1'b1, 1'b0, 1'b0, 13'h0000, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("abort sub done", int'(dut1.u_sub.done_q), 0);
    check("abort write landed", int'(mem1[13'h0777]), 8'h3C);
    @(posedge clk);
    #1;
    run_access(1, 1'b1, 1'b0, 13'h0777, 8'h00, 3, 8'h3C, 0, "abort reread");

    // RD_LAT=3: main read, sub write arriving during WAIT.
    fork
      run_access(3, 1'b0, 1'b0, 13'h0456, 8'h00, 5, 8'h99, 0, "lat3 main read");
      begin
        repeat (3) @(posedge clk);
        #1;
        run_access(3, 1'b1, 1'b1, 13'h0ABC, 8'h5E, 4, 8'h00, 0, "lat3 sub write");
      end
    join
    check("lat3 write landed", int'(mem3[13'h0ABC]), 8'h5E);

    // Asynchronous reset in the middle of a WAIT.
    set_req(3, 1'b0, 1'b1, 1'b0, 13'h0456, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset state WAIT", int'(dut3.state_q), int'(WAIT));
    rst3_n = 1'b0;
    #1;
    check("reset state IDLE", int'(dut3.state_q), int'(IDLE));
    check("reset main_busy follows cs", int'(m3_busy), 1);
    check("reset ram_we", int'(ram_we3), 0);
    check("reset ram_addr lat3", int'(ram_addr3), 0);
    check("reset main_dout lat3", int'(m3_dout), 0);
    check("reset sub_dout lat3", int'(s3_dout), 0);
    @(posedge clk);
    #1 rst3_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (m3_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("post-reset read busy cycles", n, 5);
    check("post-reset read dout", int'(m3_dout), 8'h99);
    @(posedge clk);
    #1 set_req(3, 1'b0, 1'b0, 1'b0, 13'h0, 8'h0);
    repeat (3) @(posedge clk);
    #1;

    check("ram1 writes all seen", wq1.size(), 0);
    check("ram3 writes all seen", wq3.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
